// File: rtl/uart_tx_arbiter_if.sv
// Bundle between four byte requesters, the round-robin arbiter and one UART transmitter.
// The arbiter takes the slave side; the requesters/transmitter (or a bench) take the master side.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        busy_flag;
  logic [1:0]  cur_grant;
  logic        err_timeout;

  modport slave (
    input  req, req_data, tx_busy,
    output ack, tx_start, tx_data, busy_flag, cur_grant, err_timeout
  );

  modport master (
    output req, req_data, tx_busy,
    input  ack, tx_start, tx_data, busy_flag, cur_grant, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter: grants a byte, pulses tx_start,
// tracks tx_busy with a start timeout, then holds off for an inter-frame gap.
module uart_tx_arbiter #(
  parameter int START_TO = 16,
  parameter int GAP_CYC  = 434
) (
  input logic          sys_clk,
  input logic          rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int CNT_MAX = ((START_TO - 1) > GAP_CYC) ? (START_TO - 1) : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       cur_grant_q, cur_grant_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [3:0]       ack_q, ack_d;
  logic             tx_start_q, tx_start_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       winner;
  logic [1:0]       cand;
  logic             found;
  logic [CNT_W-1:0] cnt_inc;

  // Search upward from the requester after the last winner; offset 4 wraps back to last_q.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    winner = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge sys_clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 2'd3;
      cur_grant_q <= 2'd0;
      tx_data_q   <= 8'h00;
      ack_q       <= 4'b0000;
      tx_start_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cur_grant_q <= cur_grant_d;
      tx_data_q   <= tx_data_d;
      ack_q       <= ack_d;
      tx_start_q  <= tx_start_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (found) state_d = S_START;
      S_START:   state_d = S_WAIT_HI;
      S_WAIT_HI: begin
        if (bus.tx_busy)          state_d = S_WAIT_LO;
        else if (cnt_q >= TO_LAST) state_d = S_IDLE;
      end
      S_WAIT_LO: if (!bus.tx_busy) state_d = S_GAP;
      S_GAP:     if (cnt_q >= GAP_LAST) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so ack shows during START and tx_start one cycle later.
  always_comb begin
    ack_d       = 4'b0000;
    tx_start_d  = 1'b0;
    err_d       = 1'b0;
    tx_data_d   = tx_data_q;
    cur_grant_d = cur_grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    busy_d      = (state_d != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          ack_d       = 4'b0001 << winner;
          tx_data_d   = bus.req_data[{winner, 3'b000} +: 8];
          cur_grant_d = winner;
          last_d      = winner;
        end
      end
      S_START: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
      end
      S_WAIT_HI: begin
        if (!bus.tx_busy) begin
          if (cnt_q >= TO_LAST) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_WAIT_LO: if (!bus.tx_busy) cnt_d = '0;
      S_GAP:     cnt_d = (cnt_q >= GAP_LAST) ? '0 : cnt_inc;
      default:   cnt_d = '0;
    endcase
  end

  assign bus.ack         = ack_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy_flag   = busy_q;
  assign bus.cur_grant   = cur_grant_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a scoreboard of expected grants/bytes checked at
// every tx_start, plus a simple transmitter model driving tx_busy.
module tb_uart_tx_arbiter;

  localparam int START_TO  = 16;
  localparam int GAP_CYC   = 434;
  localparam int FRAME_CYC = 4340;

  logic sys_clk = 1'b0;
  logic rst     = 1'b0;
  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .START_TO (START_TO),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [1:0] grant;
    logic [7:0] data;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks   = 0;
  int     n_errors   = 0;
  bit     model_en   = 1'b0;
  int     busy_len   = 10;
  bit     spacing_en = 1'b0;
  longint cyc        = 0;
  longint prev_start = -1;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return bus.ack != 4'b0000;
      1:       return bus.tx_start === 1'b1;
      2:       return bus.err_timeout === 1'b1;
      3:       return bus.busy_flag === 1'b0;
      4:       return bus.tx_busy === 1'b1;
      default: return bus.tx_busy === 1'b0;
    endcase
  endfunction

  // Waits on negedges until the condition holds; an expired budget is a failed check.
  task automatic wait_for(input string tag, input int which, input int budget, output int cycles);
    bit got = 1'b0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge sys_clk);
      cycles++;
      got = cond(which);
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
  endtask

  // Transmitter model: busy from the tx_start cycle for busy_len cycles, abandoned on reset.
  initial begin : xmtr
    forever begin
      @(posedge sys_clk);
      #2;
      if (model_en && !rst && bus.tx_start === 1'b1) begin
        bus.tx_busy = 1'b1;
        for (int i = 0; i < busy_len && !rst; i++) begin
          @(posedge sys_clk);
          #2;
        end
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard and invariant monitor.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!rst) begin
        if (bus.ack != 4'b0000)
          chk("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
        if (bus.tx_start === 1'b1 || bus.err_timeout === 1'b1)
          chk("start_err_exclusive", 32'(bus.tx_start & bus.err_timeout), 32'd0);
        if (bus.tx_start === 1'b1) begin
          chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_grant", 32'(bus.cur_grant), 32'(e.grant));
            chk("sb_data", 32'(bus.tx_data), 32'(e.data));
          end
          if (spacing_en && prev_start >= 0)
            chk("start_spacing", 32'((cyc - prev_start) >= longint'(FRAME_CYC + GAP_CYC + 2)), 32'd1);
          prev_start = cyc;
        end
      end
    end
  end

  initial begin : watchdog
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int cnt;
    logic [3:0] exp_ack [5];
    exp_t       rr_exp  [5];

    bus.req      = 4'b0000;
    bus.req_data = 32'hAA55_03C3;
    bus.tx_busy  = 1'b0;

    // Asynchronous reset takes effect before the first clock edge.
    #1 rst = 1'b1;
    #3;
    chk("rst_ack",       32'(bus.ack),         32'd0);
    chk("rst_tx_start",  32'(bus.tx_start),    32'd0);
    chk("rst_err",       32'(bus.err_timeout), 32'd0);
    chk("rst_busy_flag", 32'(bus.busy_flag),   32'd0);
    chk("rst_cur_grant", 32'(bus.cur_grant),   32'd0);
    chk("rst_tx_data",   32'(bus.tx_data),     32'd0);
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;

    // Single request, clean handshake.
    model_en = 1'b1;
    busy_len = 10;
    exp_q.push_back('{grant: 2'd1, data: 8'h03});
    @(negedge sys_clk);
    bus.req = 4'b0010;
    wait_for("t1_ack", 0, 8, n);
    chk("t1_ack_latency", 32'(n), 32'd1);
    chk("t1_ack",         32'(bus.ack),       32'b0010);
    chk("t1_cur_grant",   32'(bus.cur_grant), 32'd1);
    chk("t1_tx_data",     32'(bus.tx_data),   32'h03);
    bus.req = 4'b0000;
    @(negedge sys_clk);
    chk("t1_ack_pulse", 32'(bus.ack),       32'd0);
    chk("t1_tx_start",  32'(bus.tx_start),  32'd1);
    chk("t1_busy_flag", 32'(bus.busy_flag), 32'd1);
    wait_for("t1_idle", 3, 600, n);

    // Reset while the frame is shifting (WAIT_LO).
    bus.req_data = 32'h2117_0D03;
    exp_q.push_back('{grant: 2'd2, data: 8'h17});
    bus.req = 4'b0100;
    wait_for("t2_ack", 0, 8, n);
    chk("t2_ack", 32'(bus.ack), 32'b0100);
    bus.req = 4'b0000;
    wait_for("t2_tx_busy", 4, 10, n);
    repeat (3) @(negedge sys_clk);
    #2 rst = 1'b1;
    #1;
    chk("t2_rst_ack",       32'(bus.ack),         32'd0);
    chk("t2_rst_tx_start",  32'(bus.tx_start),    32'd0);
    chk("t2_rst_err",       32'(bus.err_timeout), 32'd0);
    chk("t2_rst_busy_flag", 32'(bus.busy_flag),   32'd0);
    chk("t2_rst_cur_grant", 32'(bus.cur_grant),   32'd0);
    chk("t2_rst_tx_data",   32'(bus.tx_data),     32'd0);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    exp_q.push_back('{grant: 2'd0, data: 8'h03});
    bus.req = 4'b1001;
    wait_for("t2_post_ack", 0, 8, n);
    chk("t2_post_ack",       32'(bus.ack),       32'b0001);
    chk("t2_post_cur_grant", 32'(bus.cur_grant), 32'd0);
    bus.req = 4'b0000;
    wait_for("t2_idle", 3, 600, n);

    // Fresh reset so contention starts searching from requester 0.
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;

    // Full contention with a long frame per grant.
    busy_len   = FRAME_CYC;
    spacing_en = 1'b1;
    prev_start = -1;
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_exp  = '{'{2'd0, 8'h03}, '{2'd1, 8'h0D}, '{2'd2, 8'h17}, '{2'd3, 8'h21}, '{2'd0, 8'h03}};
    for (int k = 0; k < 5; k++) exp_q.push_back(rr_exp[k]);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_for("t3_ack", 0, FRAME_CYC + GAP_CYC + 50, n);
      chk("t3_ack", 32'(bus.ack), 32'(exp_ack[k]));
    end
    bus.req = 4'b0000;
    wait_for("t3_idle", 3, FRAME_CYC + GAP_CYC + 50, n);
    spacing_en = 1'b0;
    chk("t3_sb_drained", 32'(exp_q.size()), 32'd0);

    // Start timeout: transmitter never raises busy.
    model_en    = 1'b0;
    bus.tx_busy = 1'b0;
    exp_q.push_back('{grant: 2'd2, data: 8'h17});
    bus.req = 4'b0100;
    wait_for("t4_ack", 0, 8, n);
    chk("t4_ack", 32'(bus.ack), 32'b0100);
    bus.req = 4'b0000;
    wait_for("t4_tx_start", 1, 5, n);
    wait_for("t4_err", 2, START_TO + 10, n);
    chk("t4_err_delay", 32'(n), 32'(START_TO));
    @(negedge sys_clk);
    chk("t4_busy_drop", 32'(bus.busy_flag),   32'd0);
    chk("t4_err_pulse", 32'(bus.err_timeout), 32'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (bus.tx_start === 1'b1) cnt++;
    end
    chk("t4_no_restart", 32'(cnt), 32'd0);

    // Late request during WAIT_LO is served only after the gap.
    model_en = 1'b1;
    busy_len = 30;
    exp_q.push_back('{grant: 2'd0, data: 8'h03});
    bus.req = 4'b0001;
    wait_for("t5_ack", 0, 8, n);
    chk("t5_ack", 32'(bus.ack), 32'b0001);
    bus.req = 4'b0000;
    wait_for("t5_tx_busy", 4, 10, n);
    repeat (2) @(negedge sys_clk);
    exp_q.push_back('{grant: 2'd2, data: 8'h17});
    bus.req = 4'b0100;
    wait_for("t5_busy_fall", 5, 60, n);
    wait_for("t5_late_ack", 0, GAP_CYC + 20, n);
    chk("t5_late_ack_delay", 32'(n), 32'(GAP_CYC + 2));
    chk("t5_late_ack",       32'(bus.ack), 32'b0100);
    model_en = 1'b0;
    bus.req  = 4'b0000;

    // Request raised and withdrawn inside WAIT_HI is lost.
    wait_for("t5_tx_start", 1, 5, n);
    @(negedge sys_clk);
    bus.req = 4'b0010;
    @(negedge sys_clk);
    bus.req     = 4'b0000;
    bus.tx_busy = 1'b1;
    repeat (5) @(negedge sys_clk);
    bus.tx_busy = 1'b0;
    cnt = 0;
    repeat (GAP_CYC + 40) begin
      @(negedge sys_clk);
      if (bus.ack != 4'b0000) cnt++;
    end
    chk("t5_withdrawn_no_ack", 32'(cnt), 32'd0);
    chk("t5_idle",             32'(bus.busy_flag), 32'd0);
    chk("sb_drained",          32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter START_TO, default 16, sets the maximum cycles from tx_start to tx_busy rising before a timeout is declared.
REQ-002 Parameter GAP_CYC, default 434, sets the idle cycles inserted after each frame; the default is one bit time at 50 MHz / 115200 baud.
REQ-003 sys_clk  input  1  system clock, rising-edge active.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  per-requester byte request, bit i = requester i, held high until ack[i].
REQ-006 req_data  input  32  requester i byte at bits [8i+7:8i].
REQ-007 ack  output  4  one-cycle pulse; ack[i] means requester i's byte has been latched.
REQ-008 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 tx_data  output  8  byte presented to the transmitter, stable from tx_start until the next grant.
REQ-010 tx_busy  input  1  transmitter busy flag, high while a frame is shifting.
REQ-011 busy_flag  output  1  high whenever the FSM is not in IDLE.
REQ-012 cur_grant  output  2  index of the most recently granted requester.
REQ-013 err_timeout  output  1  one-cycle pulse when tx_busy fails to rise.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, START, WAIT_HI, WAIT_LO and GAP.
REQ-015 In IDLE with req != 0, the arbiter SHALL pick the first set bit, searching upward from (last+1) mod 4 with wrap-around.
- In that same cycle it latches the winner's byte into tx_data, pulses ack[winner], sets last = cur_grant = winner and goes to START.
REQ-016 In IDLE with req == 0, the arbiter SHALL stay in IDLE and change no output.
REQ-017 START SHALL assert tx_start for exactly one cycle, clear the timeout counter and go to WAIT_HI.
- Grant-to-tx_start latency: 1 cycle.
REQ-018 WAIT_HI SHALL go to WAIT_LO when tx_busy=1.
- Otherwise it increments the counter.
- When the counter reaches START_TO-1 with tx_busy still 0, it pulses err_timeout and goes to IDLE.
REQ-019 WAIT_LO SHALL go to GAP on the first cycle with tx_busy=0; it has no timeout.
REQ-020 GAP SHALL count GAP_CYC cycles, then go to IDLE.
- A new tx_start therefore occurs no earlier than GAP_CYC+2 cycles after tx_busy falls.
REQ-021 req SHALL be sampled only in IDLE.
- Requests raised or dropped in other states have no effect until IDLE.
- A request withdrawn before its ack is simply lost; no ack is issued.
REQ-022 A requester that keeps req high after ack SHALL be treated as a new request in the next IDLE.
- Round-robin still serves every other pending requester first.
REQ-023 ack SHALL be one-hot or zero in every cycle.
REQ-024 tx_start and err_timeout SHALL never both be high in the same cycle.
REQ-025 tx_busy already high in START SHALL be ignored; WAIT_HI then exits on its first cycle.
REQ-026 The timeout counter SHALL be wide enough for both START_TO-1 and GAP_CYC, and SHALL saturate without wrapping.

Reset
REQ-027 rst=1 SHALL force the following immediately, independent of sys_clk: state=IDLE, last=3, cur_grant=0, tx_data=0x00, tx_start=0, ack=0, err_timeout=0, busy_flag=0, counter=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no ack and no err_timeout.
- After rst is released, the first grant searches from requester 0.
REQ-029 The first IDLE evaluation SHALL occur on the first sys_clk rising edge after rst deasserts.

Verification
REQ-030 Single request, clean handshake: req=4'b0010, req_data[15:8]=0x03 -> ack=4'b0010 for one cycle, cur_grant=1, tx_data=0x03, and tx_start high in the following cycle.
REQ-031 Full contention with round-robin order: req=4'b1111 held, bytes 0x03/0x0D/0x17/0x21 (requesters 0-3), and a transmitter model holding busy for 4340 cycles per frame.
- Required response: grants 0,1,2,3,0 in that order, tx_data matching each winner's byte, and tx_start spacing >= 4340+GAP_CYC+2 cycles.
REQ-032 Timeout: tx_busy tied to 0 -> err_timeout pulses exactly START_TO cycles after tx_start, busy_flag drops on the next cycle, and no second tx_start occurs without a new IDLE grant.
REQ-033 Reset mid-frame: rst pulsed while in WAIT_LO -> all outputs take their REQ-027 values with no clock edge needed; after release, req=4'b1001 grants requester 0 first.
REQ-034 Late and withdrawn requests: req[2] raised during WAIT_LO -> no ack until the state after GAP; req[1] raised and dropped within WAIT_HI -> ack[1] never asserts.
